// File: rtl/paced_output_queue.sv
// Small FIFO that presents each queued word on q for DWELL enabled cycles, pacing fast
// producer updates down to a human-readable rate for LEDs or segment displays.
module paced_output_queue #(
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 12500000,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enb,
  input  logic [N-1:0]               d,
  input  logic                       d_valid,
  output logic                       d_ready,
  output logic [N-1:0]               q,
  output logic                       q_strobe,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

  typedef enum logic {StIdle, StHold} state_e;

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  state_e        state;
  logic          push;
  logic          pop;
  logic          dwell_done;

  // Readiness depends on registered level only, so a same-cycle pop never frees a full FIFO.
  assign d_ready    = !reset && (level < LvlFull);
  assign push       = d_valid && d_ready;
  assign dwell_done = (state == StIdle) || (cnt == CntLast);
  assign pop        = enb && (level != '0) && dwell_done;
  assign busy       = (state == StHold) || (level != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      state    <= StIdle;
      q        <= '0;
      q_strobe <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d;
        wr_ptr      <= wr_ptr + PW'(1);
      end

      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (!push && pop) begin
        level <= level - LW'(1);
      end

      q_strobe <= 1'b0;
      if (enb) begin
        unique case (state)
          StIdle: begin
            if (level != '0) begin
              q        <= mem[rd_ptr];
              rd_ptr   <= rd_ptr + PW'(1);
              cnt      <= '0;
              q_strobe <= 1'b1;
              state    <= StHold;
            end
          end
          StHold: begin
            if (cnt != CntLast) begin
              cnt <= cnt + CW'(1);
            end else if (level != '0) begin
              // Back-to-back load keeps the output period exactly DWELL.
              q        <= mem[rd_ptr];
              rd_ptr   <= rd_ptr + PW'(1);
              cnt      <= '0;
              q_strobe <= 1'b1;
            end else begin
              cnt   <= '0;
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_paced_output_queue.sv
// Random and directed stimulus against a queue-based timing model, plus an order scoreboard
// that checks every strobed word against the words accepted at the input.
module tb_paced_output_queue;

  localparam int unsigned N     = 4;
  localparam int unsigned DWELL = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enb = 1'b1;
  logic [N-1:0] d = '0;
  logic         d_valid = 1'b0;
  logic         d_ready;
  logic [N-1:0] q;
  logic         q_strobe;
  logic         busy;
  logic [2:0]   level;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: list of waiting words and remaining display cycles of the shown word.
  logic [N-1:0] m_fifo[$];
  logic [N-1:0] sb[$];
  logic [N-1:0] m_q = '0;
  bit           m_strobe = 1'b0;
  int           remain = 0;

  paced_output_queue #(.N(N), .DWELL(DWELL), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enb      (enb),
    .d        (d),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .q        (q),
    .q_strobe (q_strobe),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model step and per-cycle output checks.
  initial begin
    bit accept;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_fifo.delete();
        sb.delete();
        m_q      = '0;
        m_strobe = 1'b0;
        remain   = 0;
      end else begin
        accept   = d_valid && (m_fifo.size() < DEPTH);
        m_strobe = 1'b0;
        if (enb) begin
          if (remain > 1) begin
            remain--;
          end else if (m_fifo.size() > 0) begin
            m_q      = m_fifo.pop_front();
            remain   = DWELL;
            m_strobe = 1'b1;
          end else begin
            remain = 0;
          end
        end
        if (accept) begin
          m_fifo.push_back(d);
          sb.push_back(d);
        end
      end
      #1;
      chk("q", 32'(q), 32'(m_q));
      chk("q_strobe", 32'(q_strobe), 32'(m_strobe));
      chk("level", 32'(level), 32'(m_fifo.size()));
      chk("busy", 32'(busy), 32'(remain > 0 || m_fifo.size() > 0));
      chk("d_ready", 32'(d_ready), 32'(!reset && m_fifo.size() < DEPTH));
    end
  end

  // Order scoreboard: each strobe must show the oldest accepted, not yet shown word.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q_strobe === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL order at %0t: strobe with q=%0h but no word expected", $time, q);
        end else begin
          chk("order", 32'(q), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [N-1:0] w, input logic e);
    @(negedge clk);
    d_valid = v;
    d       = w;
    enb     = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    // Reset with a word offered: nothing may be accepted.
    reset   = 1'b1;
    d_valid = 1'b1;
    d       = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d_valid = 1'b0;

    step(1'b1, 4'hA, 1'b1);
    idle(7);

    step(1'b1, 4'h1, 1'b1);
    step(1'b1, 4'h2, 1'b1);
    step(1'b1, 4'h3, 1'b1);
    idle(14);

    // Six words offered continuously into a 4-deep queue.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 4'(i), 1'b1);
      while (d_ready !== 1'b1 && !reset) step(1'b1, 4'(i), 1'b1);
    end
    idle(30);

    // Pause during the hold of 7, with pushes still offered.
    step(1'b1, 4'h7, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hB, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    idle(16);

    // Reset while holding 5 with two words queued.
    step(1'b1, 4'h5, 1'b1);
    step(1'b1, 4'h6, 1'b1);
    step(1'b1, 4'h8, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'h9, 1'b1);
    idle(8);

    // Random traffic with occasional pauses and resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d_valid = ($urandom_range(0, 2) != 0);
      d       = 4'($urandom);
      enb     = ($urandom_range(0, 5) != 0);
      reset   = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    d_valid = 1'b0;
    enb = 1'b1;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
